// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants and helpers for the parametrised register file with scoreboard.
package regfile_scoreboard_pkg;

    localparam int unsigned AAP_DATA_W   = 16;
    localparam int unsigned AAP_ADDR_W   = 6;
    localparam int unsigned AAP_NUM_REGS = 64;
    localparam int unsigned MAX_PORTS    = 32;

    // Base bit offset of slice idx in a packed vector of width-bit fields.
    function automatic int unsigned slice_base(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

    // Index of the highest set bit in match, or -1 when none is set.
    function automatic int prio_sel(input logic [MAX_PORTS-1:0] match);
        int sel;
        sel = -1;
        for (int i = 0; i < int'(MAX_PORTS); i++) begin
            if (match[i]) sel = i;
        end
        return sel;
    endfunction

endpackage

// File: rtl/regfile_bypass_mux.sv
// Per-read-port write match, priority forward select and ready computation; stateless.
module regfile_bypass_mux
    import regfile_scoreboard_pkg::*;
#(
    parameter int unsigned DATA_W   = AAP_DATA_W,
    parameter int unsigned ADDR_W   = AAP_ADDR_W,
    parameter int unsigned NUM_REGS = AAP_NUM_REGS,
    parameter int unsigned NUM_WR   = 2,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned ZERO_R0  = 0
) (
    input  logic [ADDR_W-1:0]        rd_addr,
    input  logic [DATA_W-1:0]        stored_data,
    input  logic                     stored_pending,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic [NUM_WR-1:0]        wr_en,
    output logic [DATA_W-1:0]        rd_data_c,
    output logic                     rd_ready_c
);

    logic [NUM_WR-1:0] match;
    logic              in_range;
    logic              is_r0;
    int                sel;

    always_comb begin
        rd_data_c  = '0;
        rd_ready_c = 1'b1;
        match      = '0;
        in_range   = (32'(rd_addr) < NUM_REGS);
        is_r0      = (ZERO_R0 != 0) && (rd_addr == '0);
        for (int unsigned j = 0; j < NUM_WR; j++) begin
            match[j] = wr_en[j] && (wr_addr[slice_base(j, ADDR_W) +: ADDR_W] == rd_addr);
        end
        sel = prio_sel(MAX_PORTS'(match));
        // Out-of-range and hardwired-zero addresses fall through as 0 / ready.
        if (in_range && !is_r0) begin
            if ((BYPASS != 0) && (sel >= 0)) begin
                rd_data_c  = wr_data[slice_base(unsigned'(sel), DATA_W) +: DATA_W];
                rd_ready_c = 1'b1;
            end else begin
                rd_data_c  = stored_data;
                rd_ready_c = ~stored_pending;
            end
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with write bypass, per-register pending scoreboard,
// registered pending count and sticky write-collision flag.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int unsigned DATA_W   = AAP_DATA_W,
    parameter int unsigned ADDR_W   = AAP_ADDR_W,
    parameter int unsigned NUM_REGS = AAP_NUM_REGS,
    parameter int unsigned NUM_RD   = 3,
    parameter int unsigned NUM_WR   = 2,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned ZERO_R0  = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_ready,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic                     alloc_en,
    input  logic [ADDR_W-1:0]        alloc_addr,
    output logic                     alloc_stall,
    output logic [ADDR_W:0]          pending_cnt,
    output logic                     wr_collision,
    input  logic                     clear_err
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0]   regs    [NUM_REGS];
    logic [DATA_W-1:0]   wr_val  [NUM_REGS];
    logic [DATA_W-1:0]   rd_stored [NUM_RD];
    logic [NUM_RD-1:0]   rd_pend;
    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_nxt;
    logic [NUM_REGS-1:0] wr_hit;
    logic [NUM_REGS-1:0] alloc_hot;
    logic                alloc_ok;
    logic                collision_c;
    logic [CNT_W-1:0]    pop_c;

    // Per-register write merge: later (higher-index) ports override earlier ones.
    always_comb begin
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            wr_hit[r]    = 1'b0;
            wr_val[r]    = '0;
            alloc_hot[r] = (alloc_addr == ADDR_W'(r));
            for (int unsigned j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && (wr_addr[slice_base(j, ADDR_W) +: ADDR_W] == ADDR_W'(r))
                    && !((ZERO_R0 != 0) && (r == 0))) begin
                    wr_hit[r] = 1'b1;
                    wr_val[r] = wr_data[slice_base(j, DATA_W) +: DATA_W];
                end
            end
        end
    end

    assign alloc_stall = alloc_en & (|(pending & ~wr_hit & alloc_hot));
    assign alloc_ok    = alloc_en & ~alloc_stall;

    // Write clears pending, a fresh allocation on the same register wins.
    always_comb begin
        pending_nxt = '0;
        pop_c       = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            pending_nxt[r] = (pending[r] & ~wr_hit[r])
                           | (alloc_ok & alloc_hot[r] & !((ZERO_R0 != 0) && (r == 0)));
            pop_c          = pop_c + CNT_W'(pending[r]);
        end
    end

    always_comb begin
        collision_c = 1'b0;
        for (int unsigned j = 0; j < NUM_WR; j++) begin
            for (int unsigned k = j + 1; k < NUM_WR; k++) begin
                if (wr_en[j] && wr_en[k]
                    && (wr_addr[slice_base(j, ADDR_W) +: ADDR_W] == wr_addr[slice_base(k, ADDR_W) +: ADDR_W])
                    && (32'(wr_addr[slice_base(j, ADDR_W) +: ADDR_W]) < NUM_REGS)) begin
                    collision_c = 1'b1;
                end
            end
        end
    end

    // Stored-value lookup per read port; out-of-range addresses see 0 / not pending.
    always_comb begin
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            rd_stored[i] = '0;
            rd_pend[i]   = 1'b0;
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                if (rd_addr[slice_base(i, ADDR_W) +: ADDR_W] == ADDR_W'(r)) begin
                    rd_stored[i] = regs[r];
                    rd_pend[i]   = pending[r];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
            pending      <= '0;
            pending_cnt  <= '0;
            wr_collision <= 1'b0;
        end else begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                if (wr_hit[r]) regs[r] <= wr_val[r];
            end
            pending      <= pending_nxt;
            pending_cnt  <= pop_c;
            wr_collision <= collision_c | (wr_collision & ~clear_err);
        end
    end

    for (genvar i = 0; i < int'(NUM_RD); i++) begin : g_rd
        regfile_bypass_mux #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .NUM_REGS (NUM_REGS),
            .NUM_WR   (NUM_WR),
            .BYPASS   (BYPASS),
            .ZERO_R0  (ZERO_R0)
        ) u_mux (
            .rd_addr        (rd_addr[slice_base(i, ADDR_W) +: ADDR_W]),
            .stored_data    (rd_stored[i]),
            .stored_pending (rd_pend[i]),
            .wr_addr        (wr_addr),
            .wr_data        (wr_data),
            .wr_en          (wr_en),
            .rd_data_c      (rd_data[slice_base(i, DATA_W) +: DATA_W]),
            .rd_ready_c     (rd_ready[i])
        );
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: default configuration (a_*) and BYPASS=0/ZERO_R0=1/48-reg/4R3W (b_*).
module tb_regfile_scoreboard;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic [17:0] a_rd_addr;
    logic [47:0] a_rd_data;
    logic [2:0]  a_rd_ready;
    logic [11:0] a_wr_addr;
    logic [31:0] a_wr_data;
    logic [1:0]  a_wr_en;
    logic        a_alloc_en;
    logic [5:0]  a_alloc_addr;
    logic        a_alloc_stall;
    logic [6:0]  a_pending_cnt;
    logic        a_wr_collision;
    logic        a_clear_err;

    logic [23:0] b_rd_addr;
    logic [63:0] b_rd_data;
    logic [3:0]  b_rd_ready;
    logic [17:0] b_wr_addr;
    logic [47:0] b_wr_data;
    logic [2:0]  b_wr_en;
    logic        b_alloc_en;
    logic [5:0]  b_alloc_addr;
    logic        b_alloc_stall;
    logic [6:0]  b_pending_cnt;
    logic        b_wr_collision;
    logic        b_clear_err;

    int checks = 0;
    int errors = 0;

    regfile_scoreboard u_dut_a (
        .clock(clock), .reset(reset),
        .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_ready(a_rd_ready),
        .wr_addr(a_wr_addr), .wr_data(a_wr_data), .wr_en(a_wr_en),
        .alloc_en(a_alloc_en), .alloc_addr(a_alloc_addr), .alloc_stall(a_alloc_stall),
        .pending_cnt(a_pending_cnt), .wr_collision(a_wr_collision), .clear_err(a_clear_err)
    );

    regfile_scoreboard #(
        .NUM_REGS(48), .NUM_RD(4), .NUM_WR(3), .BYPASS(0), .ZERO_R0(1)
    ) u_dut_b (
        .clock(clock), .reset(reset),
        .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_ready(b_rd_ready),
        .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_en(b_wr_en),
        .alloc_en(b_alloc_en), .alloc_addr(b_alloc_addr), .alloc_stall(b_alloc_stall),
        .pending_cnt(b_pending_cnt), .wr_collision(b_wr_collision), .clear_err(b_clear_err)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        a_wr_en = '0; a_alloc_en = 1'b0; a_clear_err = 1'b0;
        b_wr_en = '0; b_alloc_en = 1'b0; b_clear_err = 1'b0;
    endtask

    task automatic a_wr(input int p, input logic [5:0] ad, input logic [15:0] d);
        a_wr_addr[p*6 +: 6] = ad; a_wr_data[p*16 +: 16] = d; a_wr_en[p] = 1'b1;
    endtask

    task automatic b_wr(input int p, input logic [5:0] ad, input logic [15:0] d);
        b_wr_addr[p*6 +: 6] = ad; b_wr_data[p*16 +: 16] = d; b_wr_en[p] = 1'b1;
    endtask

    task automatic a_rd(input int p, input logic [5:0] ad);
        a_rd_addr[p*6 +: 6] = ad;
    endtask

    task automatic b_rd(input int p, input logic [5:0] ad);
        b_rd_addr[p*6 +: 6] = ad;
    endtask

    function automatic logic [15:0] a_d(input int p);
        return a_rd_data[p*16 +: 16];
    endfunction

    function automatic logic [15:0] b_d(input int p);
        return b_rd_data[p*16 +: 16];
    endfunction

    initial begin
        a_rd_addr = '0; a_wr_addr = '0; a_wr_data = '0; a_alloc_addr = '0;
        b_rd_addr = '0; b_wr_addr = '0; b_wr_data = '0; b_alloc_addr = '0;
        idle();
        #1;
        chk("reset_rd_data", a_d(0), 16'h0000);
        chk("reset_cnt", 16'(a_pending_cnt), 16'd0);
        chk("reset_coll", 16'(a_wr_collision), 16'd0);
        #2 reset = 1'b1;

        // Reset mid-operation: stored data and in-flight allocation both vanish
        tick();
        a_wr(0, 6'd5, 16'h1234);
        a_alloc_en = 1'b1; a_alloc_addr = 6'd10;
        tick();
        idle();
        a_rd(0, 6'd5); a_rd(1, 6'd10);
        #1;
        chk("pre_reset_r5", a_d(0), 16'h1234);
        chk("pre_reset_r10_ready", 16'(a_rd_ready[1]), 16'd0);
        tick();
        chk("pre_reset_cnt", 16'(a_pending_cnt), 16'd1);
        #1 reset = 1'b0;
        #1;
        chk("mid_reset_r5", a_d(0), 16'h0000);
        chk("mid_reset_r10_ready", 16'(a_rd_ready[1]), 16'd1);
        chk("mid_reset_cnt", 16'(a_pending_cnt), 16'd0);
        chk("mid_reset_coll", 16'(a_wr_collision), 16'd0);
        #1 reset = 1'b1;

        // Same-cycle bypass (A) versus stored value (B)
        tick();
        a_wr(0, 6'd3, 16'hBEEF); a_rd(1, 6'd3);
        b_wr(0, 6'd3, 16'hBEEF); b_rd(1, 6'd3);
        #1;
        chk("bypass_data", a_d(1), 16'hBEEF);
        chk("bypass_ready", 16'(a_rd_ready[1]), 16'd1);
        chk("nobypass_data", b_d(1), 16'h0000);
        chk("nobypass_ready", 16'(b_rd_ready[1]), 16'd1);
        tick();
        idle();
        #1;
        chk("nobypass_after_edge", b_d(1), 16'hBEEF);

        // Scoreboard: allocate, WAW stall, write-back readiness, counter
        a_alloc_en = 1'b1; a_alloc_addr = 6'd7; a_rd(2, 6'd7);
        #1;
        chk("alloc_r7_stall", 16'(a_alloc_stall), 16'd0);
        chk("alloc_r7_ready_before", 16'(a_rd_ready[2]), 16'd1);
        tick();
        idle();
        #1;
        chk("r7_pending_ready", 16'(a_rd_ready[2]), 16'd0);
        tick();
        chk("r7_cnt", 16'(a_pending_cnt), 16'd1);
        a_alloc_en = 1'b1; a_alloc_addr = 6'd7;
        #1;
        chk("r7_waw_stall", 16'(a_alloc_stall), 16'd1);
        a_alloc_en = 1'b0;
        a_wr(1, 6'd7, 16'h0042);
        #1;
        chk("r7_wb_ready", 16'(a_rd_ready[2]), 16'd1);
        chk("r7_wb_data", a_d(2), 16'h0042);
        tick();
        idle();
        #1;
        chk("r7_ready_after", 16'(a_rd_ready[2]), 16'd1);
        chk("r7_stored", a_d(2), 16'h0042);
        tick();
        chk("r7_cnt_cleared", 16'(a_pending_cnt), 16'd0);

        // Set/clear race on r9: new producer wins
        a_alloc_en = 1'b1; a_alloc_addr = 6'd9;
        tick();
        idle();
        a_wr(0, 6'd9, 16'h5555);
        a_alloc_en = 1'b1; a_alloc_addr = 6'd9;
        a_rd(0, 6'd9);
        #1;
        chk("race_stall", 16'(a_alloc_stall), 16'd0);
        tick();
        idle();
        #1;
        chk("race_data", a_d(0), 16'h5555);
        chk("race_still_pending", 16'(a_rd_ready[0]), 16'd0);
        tick();
        chk("race_cnt", 16'(a_pending_cnt), 16'd1);
        a_wr(0, 6'd9, 16'h0000);
        tick();
        idle();
        tick();
        chk("race_cnt_cleared", 16'(a_pending_cnt), 16'd0);

        // Collision: highest port wins, sticky flag, clear, set-beats-clear
        a_wr(0, 6'd2, 16'h1111); a_wr(1, 6'd2, 16'h2222); a_rd(0, 6'd2);
        #1;
        chk("coll_bypass", a_d(0), 16'h2222);
        tick();
        idle();
        #1;
        chk("coll_stored", a_d(0), 16'h2222);
        chk("coll_flag", 16'(a_wr_collision), 16'd1);
        tick();
        chk("coll_sticky", 16'(a_wr_collision), 16'd1);
        a_clear_err = 1'b1;
        tick();
        idle();
        chk("coll_cleared", 16'(a_wr_collision), 16'd0);
        a_wr(0, 6'd2, 16'h3333); a_wr(1, 6'd2, 16'h4444); a_clear_err = 1'b1;
        tick();
        idle();
        chk("coll_set_wins", 16'(a_wr_collision), 16'd1);
        a_clear_err = 1'b1;
        tick();
        idle();
        a_wr(0, 6'd4, 16'h0004); a_wr(1, 6'd5, 16'h0005);
        tick();
        idle();
        chk("no_coll_distinct", 16'(a_wr_collision), 16'd0);

        // B: hardwired r0
        b_wr(2, 6'd0, 16'hFFFF); b_rd(3, 6'd0);
        #1;
        chk("r0_data_same_cycle", b_d(3), 16'h0000);
        chk("r0_ready", 16'(b_rd_ready[3]), 16'd1);
        tick();
        idle();
        chk("r0_data_after", b_d(3), 16'h0000);
        b_alloc_en = 1'b1; b_alloc_addr = 6'd0;
        tick();
        idle();
        chk("r0_never_pending", 16'(b_rd_ready[3]), 16'd1);
        tick();
        chk("r0_cnt", 16'(b_pending_cnt), 16'd0);

        // B: out-of-range address 50 with 48 registers
        b_wr(0, 6'd50, 16'h1234); b_wr(1, 6'd50, 16'hABCD);
        b_rd(0, 6'd50); b_rd(1, 6'd2);
        #1;
        chk("oor_read", b_d(0), 16'h0000);
        chk("oor_ready", 16'(b_rd_ready[0]), 16'd1);
        tick();
        idle();
        chk("oor_after", b_d(0), 16'h0000);
        chk("oor_no_alias", b_d(1), 16'h0000);
        chk("oor_no_coll", 16'(b_wr_collision), 16'd0);
        b_wr(1, 6'd47, 16'h4747); b_rd(2, 6'd47);
        tick();
        idle();
        chk("last_reg", b_d(2), 16'h4747);

        // B: no same-cycle readiness without bypass
        b_alloc_en = 1'b1; b_alloc_addr = 6'd4;
        tick();
        idle();
        b_wr(0, 6'd4, 16'h0404); b_rd(2, 6'd4);
        #1;
        chk("nobyp_ready_same", 16'(b_rd_ready[2]), 16'd0);
        chk("nobyp_data_same", b_d(2), 16'h0000);
        tick();
        idle();
        chk("nobyp_ready_after", 16'(b_rd_ready[2]), 16'd1);
        chk("nobyp_data_after", b_d(2), 16'h0404);

        // B: three-way write collision, port 2 wins
        b_wr(0, 6'd11, 16'h000A); b_wr(1, 6'd11, 16'h000B); b_wr(2, 6'd11, 16'h000C);
        b_rd(0, 6'd11);
        tick();
        idle();
        chk("three_port_prio", b_d(0), 16'h000C);
        chk("three_port_coll", 16'(b_wr_collision), 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the fixed 64x16, 3-read/2-write register file feeding the execution stage.
- Generalised in data width, register count, and read/write port count.
- Adds three things the original lacks:
  - write-to-read bypass;
  - a per-register pending (scoreboard) bit that lets the decoder/execute path detect RAW hazards;
  - a sticky write-collision flag.
- Sits between the 16/32-bit decoder (issue/allocate side) and the execution unit (read and write-back side).

Parameters:
- DATA_W, 16, register width in bits.
- ADDR_W, 6, register address width.
- NUM_REGS, 64, number of registers; must be at most 2**ADDR_W.
- NUM_RD, 3, number of combinational read ports.
- NUM_WR, 2, number of write ports.
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = read returns the stored value.
- ZERO_R0, 0, 1 = register 0 reads as 0, ignores writes, and is never marked pending.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i at bits [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  packed read data.
- rd_ready  out  NUM_RD  1 = addressed register is not pending, or is being written this cycle.
- wr_addr  in  NUM_WR*ADDR_W  packed write addresses.
- wr_data  in  NUM_WR*DATA_W  packed write data.
- wr_en  in  NUM_WR  per-port write enable.
- alloc_en  in  1  decoder issues an instruction with a destination register.
- alloc_addr  in  ADDR_W  destination register to mark pending.
- alloc_stall  out  1  alloc_addr is already pending and not being cleared this cycle (WAW hazard).
- pending_cnt  out  ADDR_W+1  registered count of pending registers.
- wr_collision  out  1  sticky flag: two enabled write ports targeted the same address in one cycle.
- clear_err  in  1  synchronous clear of wr_collision.

Behaviour:
- Reset (reset low, asynchronous):
  - all registers go to 0;
  - all pending bits go to 0;
  - pending_cnt = 0 and wr_collision = 0;
  - rd_data reflects zeros combinationally.
  - Reset asserted mid-operation discards any in-flight allocation; there is no partial state.
- Writes commit on the rising clock edge when wr_en[j] is set.
  - Addresses >= NUM_REGS are ignored, and no collision is raised for them.
  - If two or more enabled ports target the same address, the highest-index port wins.
  - wr_collision sets on the next edge and holds until clear_err or reset.
  - If clear_err and a new collision occur in the same cycle, set wins.
- Reads are combinational, with zero latency.
  - With BYPASS=1, if any enabled write port targets rd_addr[i] this cycle, rd_data[i] = that port's data (highest index wins). Otherwise it returns the stored value.
  - An out-of-range read address returns 0 with rd_ready=1.
  - With ZERO_R0=1, address 0 always returns 0 with rd_ready=1.
- Scoreboard, one pending bit per register:
  - Set: alloc_en high and alloc_stall low sets pending[alloc_addr] on the edge.
  - Clear: an enabled write to a pending register clears that bit on the edge.
  - Same-cycle set and clear on the same register: set wins, because a new producer supersedes the old one.
  - alloc_stall = alloc_en & pending[alloc_addr] & ~(write to alloc_addr this cycle). When stalled, no state changes from the allocation.
- rd_ready[i]:
  - equals ~pending[rd_addr[i]];
  - when BYPASS=1 it is OR'd with "write to rd_addr[i] this cycle";
  - when BYPASS=0, a same-cycle write does not make the port ready.
- pending_cnt is a registered population count of the pending vector, updated one cycle after the change. It saturates at NUM_REGS by construction.

Decomposition:
- Shared package/include holds:
  - AAP register constants (default DATA_W/ADDR_W/NUM_REGS);
  - a function returning the packed-slice base offset;
  - a priority-select function (highest-index enabled match).
- One natural sub-module: regfile_bypass_mux. It is instantiated NUM_RD times, performs the per-port write-match, priority-select and ready computation, and contains no state.
- Storage, scoreboard, collision flag and pending counter live in the top level.

Test Plan:
- Reset: write r5=0x1234; assert reset low mid-cycle → r5 reads 0 immediately; pending_cnt=0; wr_collision=0.
- Bypass: in the same cycle, write port0 r3=0xBEEF and read port1 of r3 → rd_data=0xBEEF, rd_ready=1. With BYPASS=0 → old value 0x0000.
- Scoreboard:
  - alloc r7 → next cycle rd_ready for r7 = 0 and pending_cnt=1;
  - second alloc r7 → alloc_stall=1;
  - write r7=0x0042 → rd_ready=1 in that same cycle;
  - pending_cnt=0 one edge later.
- Set/clear race: r9 pending; in one cycle write r9 and alloc r9 → alloc_stall=0; after the edge r9 holds the new data and is still pending.
- Collision: wr_en=2'b11 with both ports targeting r2 (0x1111 on port0, 0x2222 on port1) → r2=0x2222 and wr_collision=1 (sticky); clear_err → 0 next edge.
- Boundaries:
  - ZERO_R0=1: write r0=0xFFFF → reads 0, ready=1.
  - NUM_REGS=48: address 50 → reads 0, write ignored.
  - Sweep NUM_RD=4, NUM_WR=3.
